// File: rtl/display8_scanner_pkg.sv
// Shared constants and types for the eight-digit multiplexed seven-segment scanner.
package display_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [7:0] DIGIT_OFF  = 8'hFF;

   typedef logic [2:0] digit_idx_t;

   // Active-low one-cold anode select for a digit index.
   function automatic logic [7:0] digitSelectFor(input digit_idx_t idx);
      logic [7:0] oneHot;
      oneHot = 8'b0000_0001 << idx;
      return ~oneHot;
   endfunction

endpackage

// File: rtl/display8_scanner_hexto7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hexto7seg (
   input  logic [3:0] i_nibble,
   output logic [6:0] o_segments
);

   always_comb begin
      o_segments = 7'h7F;
      case (i_nibble)
         4'h0: o_segments = 7'h40;
         4'h1: o_segments = 7'h79;
         4'h2: o_segments = 7'h24;
         4'h3: o_segments = 7'h30;
         4'h4: o_segments = 7'h19;
         4'h5: o_segments = 7'h12;
         4'h6: o_segments = 7'h02;
         4'h7: o_segments = 7'h78;
         4'h8: o_segments = 7'h00;
         4'h9: o_segments = 7'h10;
         4'hA: o_segments = 7'h08;
         4'hB: o_segments = 7'h03;
         4'hC: o_segments = 7'h46;
         4'hD: o_segments = 7'h21;
         4'hE: o_segments = 7'h06;
         4'hF: o_segments = 7'h0E;
         default: o_segments = 7'h7F;
      endcase
   end

endmodule

// File: rtl/display8_scanner.sv
// Eight-digit time-multiplexed hex display driver with frame-synchronous value updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display8_scanner
   import display_pkg::*;
#(
   parameter int DIV_BITS = 17
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic        load,
   input  logic [7:0]  digit_en,
   output logic [7:0]  digitselect,
   output logic [7:0]  segments,
   output logic        pending,
   output logic        frame_tick
);

   logic [DIV_BITS-1:0] r_prescaler;
   digit_idx_t          r_index;
   logic [31:0]         r_display;
   logic [31:0]         r_pendingData;
   logic                r_pending;
   logic [7:0]          r_digitselect;
   logic [7:0]          r_segments;
   logic                r_frameTick;

   logic                w_advance;
   logic                w_boundary;
   logic [3:0]          w_nibble;
   logic [6:0]          w_hexSeg;
   logic                w_blank;

   assign w_advance  = &r_prescaler;
   assign w_boundary = w_advance && (r_index == digit_idx_t'(NUM_DIGITS - 1));
   assign w_nibble   = r_display[{r_index, 2'b00} +: 4];

   hexto7seg u_hexto7seg (
      .i_nibble   (w_nibble),
      .o_segments (w_hexSeg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more significant nibble are zero.
   assign w_blank = (r_index != '0) && ((r_display >> {r_index, 2'b00}) == 32'd0);
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_prescaler <= '0;
         r_index     <= '0;
      end else begin
         r_prescaler <= r_prescaler + DIV_BITS'(1);
         if (w_advance) begin
            r_index <= r_index + 3'd1;
         end
      end
   end

   // Loads land in the pending register; the display register changes only at a frame
   // boundary, and a load coinciding with the boundary bypasses straight to the display.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_display     <= '0;
         r_pendingData <= '0;
         r_pending     <= 1'b0;
      end else begin
         if (load) begin
            r_pendingData <= value;
         end
         if (w_boundary && load) begin
            r_display <= value;
            r_pending <= 1'b0;
         end else if (w_boundary && r_pending) begin
            r_display <= r_pendingData;
            r_pending <= 1'b0;
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_digitselect <= DIGIT_OFF;
         r_segments    <= SEG_BLANK;
         r_frameTick   <= 1'b0;
      end else begin
         r_digitselect <= digit_en[r_index] ? digitSelectFor(r_index) : DIGIT_OFF;
         r_segments    <= w_blank ? SEG_BLANK : {1'b1, w_hexSeg};
         r_frameTick   <= w_boundary;
      end
   end

   assign digitselect = r_digitselect;
   assign segments    = r_segments;
   assign pending     = r_pending;
   assign frame_tick  = r_frameTick;

endmodule
